// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants: bus widths, fetch FSM state encodings and the
// default reset PC. Imported by inst_fetch and icache_dm.
package inst_fetch_pkg;

  localparam int AddrBus = 32;
  localparam int InstBus = 32;

  localparam logic [AddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    MEM_WAIT = 2'd1,
    OUT      = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache (icache_dm).
// Lookup is combinational on a word address; fill writes one line per cycle.
// Only the valid bits are reset; tag and data contents are don't-care until
// their valid bit is set. Instantiated by inst_fetch under INST_FETCH_ICACHE_EN.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int WADDR_W = AddrBus - 2,
  parameter int DATA_W  = InstBus,
  parameter int LINES   = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WADDR_W-1:0] lookup_addr,
  output logic               lookup_hit,
  output logic [DATA_W-1:0]  lookup_data,
  input  logic               fill_en,
  input  logic [WADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0]  fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WADDR_W - IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  fl_idx;
  logic [TAG_W-1:0]  fl_tag;

  assign lk_idx = lookup_addr[IDX_W-1:0];
  assign lk_tag = lookup_addr[WADDR_W-1:IDX_W];
  assign fl_idx = fill_addr[IDX_W-1:0];
  assign fl_tag = fill_addr[WADDR_W-1:IDX_W];

  assign lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_data = data_q[lk_idx];

  // Next valid vector: a fill marks its line valid.
  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[fl_idx] = 1'b1;
    end
  end

  // Valid bits: cleared on reset, otherwise follow fills.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data storage: written on fill, never reset.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fl_idx]  <= fl_tag;
      data_q[fl_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end. Holds the PC, requests words from the memory
// controller, and presents one instruction + PC per handshake to the decoder.
// Static pc+4 prediction; ROB redirects via jump_flag/jump_addr.
// Optional I-cache enabled by defining INST_FETCH_ICACHE_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W       = AddrBus,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                ICACHE_LINES = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_done,
  input  logic [InstBus-1:0]  mem_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [InstBus-1:0]  out_inst,
  output logic [ADDR_W-1:0]   out_pc,
  input  logic                jump_flag,
  input  logic [ADDR_W-1:0]   jump_addr
);

  // The cache index math relies on a power-of-two line count.
  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("inst_fetch: ICACHE_LINES must be a power of two >= 2");
  end

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                discard_q, discard_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [InstBus-1:0]  out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

  logic                cache_hit;
  logic [InstBus-1:0]  cache_data;

`ifdef INST_FETCH_ICACHE_EN
  logic fill_en;

  // Fill only with a word that is actually delivered to the decoder.
  assign fill_en = rdy_in && !jump_flag && (state_q == MEM_WAIT) &&
                   mem_done && !discard_q;

  icache_dm #(
    .WADDR_W (ADDR_W - 2),
    .DATA_W  (InstBus),
    .LINES   (ICACHE_LINES)
  ) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_addr (pc_q[ADDR_W-1:2]),
    .lookup_hit  (cache_hit),
    .lookup_data (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (pc_q[ADDR_W-1:2]),
    .fill_data   (mem_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state logic; a redirect overrides every other event in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    if (jump_flag) begin
      pc_d        = jump_addr;
      out_valid_d = 1'b0;
      if (state_q == MEM_WAIT) begin
        if (mem_done) begin
          // Transfer completes this cycle: drop the word and refetch.
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = FETCH;
        end else begin
          // Controller still owes us a word; swallow it when it arrives.
          discard_d = 1'b1;
        end
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (cache_hit) begin
            out_inst_d  = cache_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = FETCH;
            end else begin
              out_inst_d  = mem_data;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              state_d     = OUT;
            end
          end
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            pc_d        = pc_q + ADDR_W'(4);
            out_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // Fetch FSM and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        jump_flag;
  logic [31:0] jump_addr;

  int total = 0;
  int bad   = 0;

  inst_fetch dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .jump_flag (jump_flag),
    .jump_addr (jump_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mem_done = 1'b0; mem_data = '0;
    out_ready = 1'b0; jump_flag = 1'b0; jump_addr = '0;
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_out_inst",  out_inst,       32'h0);
    chk("rst_out_pc",    out_pc,         32'h0);

    // First fetch at 0, memory answers three cycles after the request.
    rst_in = 1'b0;
    tick(1);
    chk("f0_req",  32'(mem_req), 32'd1);
    chk("f0_addr", mem_addr,     32'h0);
    tick(2);
    chk("f0_req_held", 32'(mem_req), 32'd1);
    mem_done = 1'b1; mem_data = 32'h0000_0013;
    tick(1);
    mem_done = 1'b0;
    chk("f0_valid", 32'(out_valid), 32'd1);
    chk("f0_inst",  out_inst,       32'h0000_0013);
    chk("f0_pc",    out_pc,         32'h0);

    // Decoder back-pressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_inst",  out_inst,       32'h0000_0013);
      chk("bp_pc",    out_pc,         32'h0);
      chk("bp_noreq", 32'(mem_req),   32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("acc0_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("f4_req",  32'(mem_req), 32'd1);
    chk("f4_addr", mem_addr,     32'h4);

    // Deliver pc=4, accept, then fetch at 8.
    mem_done = 1'b1; mem_data = 32'hAAAA_0004;
    tick(1);
    mem_done = 1'b0;
    chk("f4_pc",   out_pc,   32'h4);
    chk("f4_inst", out_inst, 32'hAAAA_0004);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    chk("f8_addr", mem_addr, 32'h8);

    // Redirect to 0x100 while waiting on pc=8: word for 8 must be dropped.
    jump_flag = 1'b1; jump_addr = 32'h100;
    tick(1);
    jump_flag = 1'b0;
    chk("jw_req_held",  32'(mem_req), 32'd1);
    chk("jw_addr_held", mem_addr,     32'h8);
    tick(1);
    mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick(1);
    mem_done = 1'b0;
    chk("jw_req_drop", 32'(mem_req),   32'd0);
    chk("jw_novalid",  32'(out_valid), 32'd0);
    chk("jw_noinst",   out_inst,       32'hAAAA_0004);
    tick(1);
    chk("jw_new_req",  32'(mem_req), 32'd1);
    chk("jw_new_addr", mem_addr,     32'h100);
    chk("jw_novalid2", 32'(out_valid), 32'd0);

    // Deliver 0x100, redirect to 0x20 from OUT.
    mem_done = 1'b1; mem_data = 32'h0000_0100;
    tick(1);
    mem_done = 1'b0;
    chk("f100_pc", out_pc, 32'h100);
    jump_flag = 1'b1; jump_addr = 32'h20;
    tick(1);
    jump_flag = 1'b0;
    chk("j20_novalid", 32'(out_valid), 32'd0);
    tick(1);
    chk("f20_addr", mem_addr, 32'h20);
    mem_done = 1'b1; mem_data = 32'h0000_0020;
    tick(1);
    mem_done = 1'b0;
    chk("f20_valid", 32'(out_valid), 32'd1);
    chk("f20_pc",    out_pc,         32'h20);

    // Redirect and accept in the same cycle: redirect wins.
    jump_flag = 1'b1; jump_addr = 32'h40; out_ready = 1'b1;
    tick(1);
    jump_flag = 1'b0; out_ready = 1'b0;
    chk("jacc_novalid", 32'(out_valid), 32'd0);
    tick(1);
    chk("jacc_req",  32'(mem_req), 32'd1);
    chk("jacc_addr", mem_addr,     32'h40);

    // Global stall in MEM_WAIT with a mem_done pulse during the stall.
    rdy_in = 1'b0;
    tick(1);
    mem_done = 1'b1; mem_data = 32'h5555_5555;
    tick(1);
    mem_done = 1'b0;
    tick(2);
    chk("stall_req",   32'(mem_req),   32'd1);
    chk("stall_addr",  mem_addr,       32'h40);
    chk("stall_valid", 32'(out_valid), 32'd0);
    rdy_in = 1'b1;
    tick(1);
    chk("stall_still_wait", 32'(mem_req),   32'd1);
    chk("stall_no_capture", 32'(out_valid), 32'd0);
    mem_done = 1'b1; mem_data = 32'h0000_0040;
    tick(1);
    mem_done = 1'b0;
    chk("f40_valid", 32'(out_valid), 32'd1);
    chk("f40_inst",  out_inst,       32'h0000_0040);
    chk("f40_pc",    out_pc,         32'h40);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    chk("f44_addr", mem_addr, 32'h44);

    // Reset mid-request; a late mem_done must be ignored.
    rst_in = 1'b1;
    tick(1);
    chk("rmid_req",  32'(mem_req), 32'd0);
    chk("rmid_addr", mem_addr,     32'h0);
    rst_in = 1'b0; mem_done = 1'b1; mem_data = 32'h7777_7777;
    tick(1);
    mem_done = 1'b0;
    chk("rmid_refetch", 32'(mem_req),   32'd1);
    chk("rmid_valid",   32'(out_valid), 32'd0);
    tick(1);
    chk("rmid_valid2",  32'(out_valid), 32'd0);

    // Redirect coincident with mem_done, then wrap of pc+4.
    jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFC; mem_done = 1'b1; mem_data = 32'h1111_1111;
    tick(1);
    jump_flag = 1'b0; mem_done = 1'b0;
    chk("jdone_req",   32'(mem_req),   32'd0);
    chk("jdone_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    mem_done = 1'b1; mem_data = 32'h0000_0FFC;
    tick(1);
    mem_done = 1'b0;
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    chk("wrap_next", mem_addr, 32'h0);

`ifdef INST_FETCH_ICACHE_EN
    // Loop 0 -> 4 -> jump 0: the second pass hits the cache.
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    tick(1);
    chk("c_f0_addr", mem_addr, 32'h0);
    mem_done = 1'b1; mem_data = 32'hC000_0000;
    tick(1);
    mem_done = 1'b0;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    chk("c_f4_addr", mem_addr, 32'h4);
    mem_done = 1'b1; mem_data = 32'hC000_0004;
    tick(1);
    mem_done = 1'b0;
    chk("c_f4_pc", out_pc, 32'h4);
    jump_flag = 1'b1; jump_addr = 32'h0;
    tick(1);
    jump_flag = 1'b0;
    tick(1);
    chk("c_hit0_valid", 32'(out_valid), 32'd1);
    chk("c_hit0_inst",  out_inst,       32'hC000_0000);
    chk("c_hit0_noreq", 32'(mem_req),   32'd0);
    out_ready = 1'b1;
    tick(2);
    chk("c_hit4_valid", 32'(out_valid), 32'd1);
    chk("c_hit4_pc",    out_pc,         32'h4);
    chk("c_hit4_inst",  out_inst,       32'hC000_0004);
    chk("c_hit4_noreq", 32'(mem_req),   32'd0);
    out_ready = 1'b0;
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    tick(1);
    chk("c_rst_miss_req",  32'(mem_req), 32'd1);
    chk("c_rst_miss_addr", mem_addr,     32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
